// File: rtl/pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pc_sequencer : fetch PC register with redirect priority, stall and flush   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0080,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jmp,
  input  logic [31:0] jmp_target,
  input  logic        trap,
  output logic [31:0] pc,
  output logic        pc_sel,
  output logic [31:0] pc_new,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0]  FLUSH_LOAD = 2'(FLUSH_CYCLES);
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt;
  logic        redirect;

  // Redirect resolution; everything is forced quiet while reset is held.
  always_comb begin
    redirect    = rst_n & (trap | jmp | br_taken);
    pc_new      = '0;
    if (rst_n) begin
      if (trap)          pc_new = TRAP_VEC   & ALIGN_MASK;
      else if (jmp)      pc_new = jmp_target & ALIGN_MASK;
      else if (br_taken) pc_new = br_target  & ALIGN_MASK;
    end
    pc_sel      = redirect;
    if_id_flush = redirect;
    id_ex_flush = rst_n & (redirect | stall);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc + 32'd4;
    if (redirect) begin
      pc_nxt    = pc_new;
      state_nxt = FLUSH;
      cnt_nxt   = FLUSH_LOAD;
    end else if (stall) begin
      // A stall inside FLUSH freezes the bubble count along with the PC.
      pc_nxt = pc;
      if (state != FLUSH) state_nxt = STALL;
    end else begin
      case (state)
        FLUSH: begin
          if (cnt <= 2'd1) begin
            state_nxt = RUN;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt = cnt - 2'd1;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc    <= RESET_PC;
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      pc    <= pc_nxt;
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign fetch_valid = (state != FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pc_sequencer : directed stimulus with a cycle-level reference model     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_pc_sequencer;

  localparam logic [31:0] TRAP  = 32'h0000_0080;
  localparam int          NFLSH = 2;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_taken, jmp, trap;
  logic [31:0] br_target, jmp_target;
  logic [31:0] pc, pc_new, pc2, pc_new2;
  logic        pc_sel, if_id_flush, id_ex_flush, fetch_valid;
  logic        pc_sel2, if_id_flush2, id_ex_flush2, fetch_valid2;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .trap(trap),
    .pc(pc), .pc_sel(pc_sel), .pc_new(pc_new), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .fetch_valid(fetch_valid)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken),
    .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target), .trap(trap),
    .pc(pc2), .pc_sel(pc_sel2), .pc_new(pc_new2), .if_id_flush(if_id_flush2),
    .id_ex_flush(id_ex_flush2), .fetch_valid(fetch_valid2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: a PC plus the number of invalid fetches still owed.
  logic [31:0] m_pc = '0;
  int          m_bubbles = 0;
  bit          m_ok = 1'b0;

  function automatic logic [31:0] exp_target();
    if (!rst_n)   return '0;
    if (trap)     return TRAP & ~32'd3;
    if (jmp)      return jmp_target & ~32'd3;
    if (br_taken) return br_target & ~32'd3;
    return '0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_bubbles = 0; m_ok = 1'b1;
    end else if (m_ok) begin
      if (trap || jmp || br_taken) begin
        m_pc = exp_target(); m_bubbles = NFLSH;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
        if (m_bubbles > 0) m_bubbles--;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      logic redir;
      redir = rst_n && (trap || jmp || br_taken);
      check("model_pc",          pc,          m_pc);
      check("model_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_bubbles == 0});
      check("model_pc_sel",      {31'b0, pc_sel},      {31'b0, redir});
      check("model_pc_new",      pc_new,      exp_target());
      check("model_if_id_flush", {31'b0, if_id_flush}, {31'b0, redir});
      check("model_id_ex_flush", {31'b0, id_ex_flush}, {31'b0, rst_n && (redir || stall)});
    end
  end

  task automatic set_in(input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt, input logic tr);
    stall = st; br_taken = br; br_target = bt; jmp = j; jmp_target = jt; trap = tr;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    next_cycle();
    next_cycle();
    set_in(1, 1, 32'h44, 1, 32'h88, 1);
    @(negedge clk);
    check("rst_pc_sel", {31'b0, pc_sel}, 32'd0);
    check("rst_pc_new", pc_new, 32'd0);
    check("rst_flush", {30'b0, if_id_flush, id_ex_flush}, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    idle();

    // Idle run from reset, both instances.
    @(negedge clk); check("idle_pc0", pc, 32'h0); check("idle_fv0", {31'b0, fetch_valid}, 32'd1);
    check("wrap_pc0", pc2, 32'hFFFF_FFF8);
    next_cycle(); @(negedge clk); check("idle_pc4", pc, 32'h4); check("wrap_pc1", pc2, 32'hFFFF_FFFC);
    next_cycle(); @(negedge clk); check("idle_pc8", pc, 32'h8); check("wrap_pc2", pc2, 32'h0);
    next_cycle(); @(negedge clk); check("idle_pc12", pc, 32'hC); check("idle_sel", {31'b0, pc_sel}, 32'd0);
    next_cycle();

    // Branch with misaligned target at pc = 0x10.
    set_in(0, 1, 32'h203, 0, 0, 0);
    @(negedge clk);
    check("br_pc", pc, 32'h10); check("br_pc_new", pc_new, 32'h200);
    check("br_sel", {31'b0, pc_sel}, 32'd1);
    check("br_flush", {30'b0, if_id_flush, id_ex_flush}, 32'd3);
    next_cycle(); idle();
    @(negedge clk); check("br_f1_pc", pc, 32'h200); check("br_f1_fv", {31'b0, fetch_valid}, 32'd0);
    next_cycle(); @(negedge clk); check("br_f2_pc", pc, 32'h204); check("br_f2_fv", {31'b0, fetch_valid}, 32'd0);
    next_cycle(); @(negedge clk); check("br_run_pc", pc, 32'h208); check("br_run_fv", {31'b0, fetch_valid}, 32'd1);

    // Reach 0x20 and stall for three edges.
    next_cycle(); set_in(0, 0, 0, 1, 32'h18, 0);
    next_cycle(); idle(); next_cycle(); next_cycle();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_pc", pc, 32'h20);
      check("stall_flush", {30'b0, if_id_flush, id_ex_flush}, 32'd1);
      next_cycle();
    end
    stall = 1'b0;
    @(negedge clk); check("stall_rel_pc", pc, 32'h20);
    next_cycle(); @(negedge clk); check("stall_after_pc", pc, 32'h24);

    // Trap beats jmp and branch; then jmp beats branch inside FLUSH.
    set_in(0, 1, 32'h300, 1, 32'h400, 1);
    @(negedge clk); check("trap_pc_new", pc_new, 32'h80);
    next_cycle(); set_in(0, 1, 32'h300, 1, 32'h400, 0);
    @(negedge clk); check("trap_pc", pc, 32'h80); check("jmp_pc_new", pc_new, 32'h400);
    next_cycle(); idle();
    @(negedge clk); check("jmp_pc", pc, 32'h400);
    next_cycle(); next_cycle();
    @(negedge clk); check("jmp_run_pc", pc, 32'h408); check("jmp_run_fv", {31'b0, fetch_valid}, 32'd1);

    // Stall inside FLUSH freezes pc and bubble count.
    set_in(0, 0, 0, 1, 32'h501, 0);
    next_cycle(); set_in(1, 0, 0, 0, 0, 0);
    next_cycle(); next_cycle(); stall = 1'b0;
    @(negedge clk); check("fstall_pc", pc, 32'h500); check("fstall_fv", {31'b0, fetch_valid}, 32'd0);
    next_cycle(); @(negedge clk); check("fstall_pc1", pc, 32'h504); check("fstall_fv1", {31'b0, fetch_valid}, 32'd0);
    next_cycle(); @(negedge clk); check("fstall_pc2", pc, 32'h508); check("fstall_fv2", {31'b0, fetch_valid}, 32'd1);

    // Branch arriving during STALL.
    stall = 1'b1;
    next_cycle(); set_in(1, 1, 32'h600, 0, 0, 0);
    @(negedge clk); check("sbr_pc", pc, 32'h508); check("sbr_pc_new", pc_new, 32'h600);
    next_cycle(); idle(); next_cycle(); next_cycle();
    @(negedge clk); check("sbr_run_pc", pc, 32'h608);

    // PC wrap through the top of the address space.
    set_in(0, 0, 0, 1, 32'hFFFF_FFF4, 0);
    next_cycle(); idle(); next_cycle(); next_cycle(); next_cycle();
    @(negedge clk); check("wrap_pc", pc, 32'h0);

    // Reset during the first FLUSH cycle after a jump.
    next_cycle(); set_in(0, 0, 0, 1, 32'h100, 0);
    next_cycle(); idle();
    @(negedge clk); check("rflush_pc", pc, 32'h100);
    rst_n = 1'b0; set_in(1, 1, 32'h300, 1, 32'h400, 1);
    @(negedge clk); check("rflush_sel", {31'b0, pc_sel}, 32'd0);
    next_cycle(); rst_n = 1'b1; idle();
    @(negedge clk); check("rflush_pc_rst", pc, 32'h0); check("rflush_fv", {31'b0, fetch_valid}, 32'd1);
    next_cycle(); @(negedge clk); check("rflush_pc4", pc, 32'h4); check("rflush_fv4", {31'b0, fetch_valid}, 32'd1);
    next_cycle(); next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
